// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmitter FSM states and parity mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/baud_tick_det.sv
// Turns the bit-rate square wave into a one-cycle tick on each rising edge.
module baud_tick_det (
  input  logic sys_clk,
  input  logic rst,
  input  logic baud_clk,
  output logic tick
);

  logic baud_q;

  // Reset to 1 so a wave that is already high when reset releases gives no tick.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      baud_q <= 1'b1;
    end else begin
      baud_q <= baud_clk;
    end
  end

  assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register feeding a tick-paced frame shifter
// (start bit, LSB-first data, optional parity, one or two stop bits).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy
);

  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic       HAS_PAR   = (PARITY != PAR_NONE);

  tx_state_t            state_q, state_d;
  logic                 txd_q, txd_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tick;
  logic                 start_frame;

  baud_tick_det u_tick (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .baud_clk (baud_clk),
    .tick     (tick)
  );

  always_comb begin
    state_d      = state_q;
    txd_d        = txd_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    par_d        = par_q;
    start_frame  = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (hold_valid_q) start_frame = 1'b1;
        end
        ST_START: begin
          state_d   = ST_DATA;
          txd_d     = shift_q[0];
          bit_cnt_d = 3'd0;
        end
        ST_DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            stop_cnt_d = 1'b0;
            if (HAS_PAR) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          if (stop_cnt_q == STOP_LAST) begin
            if (hold_valid_q) begin
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end

    // Same loads whether the frame starts from idle or back-to-back after a stop bit.
    if (start_frame) begin
      state_d      = ST_START;
      txd_d        = 1'b0;
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
      par_d        = (PARITY == PAR_ODD) ? ~^hold_data_q : ^hold_data_q;
    end

    if (tx_valid && !hold_valid_q) begin
      hold_data_d  = tx_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      txd_q        <= 1'b1;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= 3'd0;
      stop_cnt_q   <= 1'b0;
      par_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      txd_q        <= txd_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      par_q        <= par_d;
    end
  end

  assign tx_ready = ~hold_valid_q;
  assign txd      = txd_q;
  assign tx_busy  = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter directly downstream of `baud_gen`. It consumes the `baud_clk` square wave as a level signal in the `sys_clk` domain and treats each rising edge as one bit-period tick. It accepts bytes over a valid/ready handshake into a one-deep holding register, then shifts out UART frames on `txd`: start bit, data LSB-first, optional parity, stop bit(s). At 50 MHz with `baud_gen`, one bit lasts 434 `sys_clk` cycles (115207 baud).

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal values 5–8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.

- `sys_clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  synchronous, active-high reset.
- `baud_clk`  in  1  bit-rate square wave, already synchronous to `sys_clk`. Each 0→1 transition is one tick.
- `tx_data`  in  DATA_BITS  byte to send; sampled on accept.
- `tx_valid`  in  1  upstream offers `tx_data`.
- `tx_ready`  out  1  holding register empty; equals `!hold_valid`.
- `txd`  out  1  serial line, idle high; registered.
- `tx_busy`  out  1  high while a frame is on the line (state ≠ IDLE).

## Operation
- **Tick detection**
  - `baud_d` is a registered copy of `baud_clk`.
  - `tick = baud_clk & ~baud_d`.
  - Reset sets `baud_d` to 1, so a `baud_clk` that is high when reset releases does not produce a spurious tick.
- **Accept**
  - A transfer occurs when `tx_valid && tx_ready`.
  - On accept, `tx_data` loads into `hold_data` and `hold_valid` is set.
  - Data accepted in a tick cycle is not visible to that tick.
- **States**: IDLE, START, DATA, PARITY, STOP. All transitions happen only in cycles where `tick=1`.
  - IDLE with `hold_valid`: go to START, `txd←0`, load the shifter from `hold_data`, clear `hold_valid`, compute parity over the data.
  - START: go to DATA, `txd←shift[0]`, `bit_cnt←0`.
  - DATA: shift right and increment `bit_cnt`.
    - After the tick that ends bit `DATA_BITS-1`, go to PARITY if `PARITY≠0`, otherwise to STOP.
    - In both cases `txd` takes the parity bit or 1 accordingly.
  - PARITY: go to STOP, `txd←1`.
    - Odd parity: parity bit = ~^data.
    - Even parity: parity bit = ^data.
  - STOP: `stop_cnt` counts `STOP_BITS` ticks. On the tick that ends the last stop bit:
    - if `hold_valid`, go directly to START (back-to-back, no idle gap), with the same loads as IDLE→START;
    - otherwise go to IDLE with `txd` held at 1.
- **Frame length**: 1 + `DATA_BITS` + (`PARITY≠0`) + `STOP_BITS` ticks.
- **Reset mid-frame**: at the next `sys_clk` edge, `txd=1`, state = IDLE, `hold_valid=0`, `tx_ready=1`. The partial frame and any held byte are dropped.
- **Holding full**: `tx_ready=0`. `tx_valid` is ignored, and upstream must hold its data until `tx_ready` returns.
- **Hold-to-shifter transfer**: clearing `hold_valid` and presenting `tx_ready=1` occur in the same cycle. A new accept takes effect at the following edge.

## Timing
- **Reset values**: `txd=1`, `tx_ready=1`, `tx_busy=0`, `hold_valid=0`, `baud_d=1`, state = IDLE.
- **Bit-edge latency**: `txd` changes at the `sys_clk` edge that ends the cycle in which `baud_clk` is first seen high. This is one cycle after `baud_clk` rises.
- **Start latency**: from accept into an idle block, the start bit begins at the first tick strictly after the accept cycle.
- **Ready recovery**: `tx_ready` rises one cycle after the tick that moves the held byte into the shifter. Upstream therefore has a full frame time to refill the holding register.
- **Bit width**: each bit lasts exactly one `baud_clk` period. There is no internal division.

## Structure
- **Package `uart_pkg`**:
  - state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity constants `PAR_NONE=0`, `PAR_ODD=1`, `PAR_EVEN=2`.
- **Sub-module `baud_tick_det`**: the `baud_d` register plus rising-edge detect, outputting `tick`. It is reusable by the future `uart_rx`.
- **Remainder**: one FSM plus the datapath registers (`hold_data`, `shift`, `bit_cnt`, `stop_cnt`, `par`).

## Test plan
For speed, the bench drives `baud_clk` directly, toggling every 4 cycles (tick period 8 cycles) unless stated otherwise.

1. **No parity, 1 stop**: send 0x55 → `txd` = 0,1,0,1,0,1,0,1,0,1, 8 cycles per bit; `tx_busy` high for exactly 80 cycles; then IDLE with `txd=1`.
2. **Even parity, 2 stops**: send 0x07 → 0, 1,1,1,0,0,0,0,0, parity 1, 1, 1. Repeat with odd parity → parity bit 0.
3. **Back-to-back**: hold `tx_valid` high with 0xA5 then 0x3C → second start bit immediately follows the first stop bit with no gap; `tx_ready` low from the second accept until one cycle after the second frame's start tick.
4. **Reset mid-frame**: assert `rst` during data bit 3 with a byte held → next edge: `txd=1`, `tx_ready=1`, `tx_busy=0`; after release, no frame appears without a new accept.
5. **Reset release with `baud_clk` high**: no tick, no `txd` activity. Accept 0xFF → start bit begins at the next true rising edge.
6. **`DATA_BITS=5`, using `baud_gen` at 50 MHz**: send 0x1F → 7-bit frame, each bit 434 cycles, `txd` = 0,1,1,1,1,1,1.
